mult_tree_arbiter: RTL
======================

Name: mult_tree_arbiter

Overview:
- Shares one product-tree datapath (NUM inputs of DATA_WIDTH bits, 32-bit fixed-point product, fully pipelined, no backpressure, no reset) among REQ requesters.
- Round-robin grant, at most one issue per cycle. Tags every issued operation in an in-order tag FIFO and routes each tree result back to its originating requester.
- Sits between the requester blocks and the product tree instance.

Parameters:
- NUM, 8, operands per product (tree input count).
- DATA_WIDTH, 8, operand width in bits.
- REQ, 4, number of requesters, ≥2.
- MAX_INFLIGHT, 8, maximum outstanding tree operations; also the tag FIFO depth; power of two.
- ID_W, $clog2(REQ), requester id width (derived, not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  REQ  per-requester operation request.
- req_data  in  REQ*NUM*DATA_WIDTH  operand vector; requester r occupies slice r.
- req_ready  out  REQ  grant; combinational, one-hot or zero.
- tree_din  out  NUM*DATA_WIDTH  operands to the tree, registered.
- tree_din_tvalid  out  NUM  all bits equal; registered.
- tree_dout  in  32  tree product.
- tree_dout_tvalid  in  1  tree result strobe.
- res_valid  out  REQ  one-cycle result pulse to the owning requester, registered.
- res_data  out  32  result, shared across requesters, registered.
- res_id  out  ID_W  owner id of the current result, registered.
- inflight  out  $clog2(MAX_INFLIGHT)+1  outstanding operation count.
- busy  out  1  high when inflight != 0.
- err_orphan  out  1  sticky flag: a result arrived with no tag outstanding.

Behaviour:
- Reset (async assert, sync release):
  - tree_din=0, tree_din_tvalid=0, res_valid=0, res_data=0, res_id=0, inflight=0, busy=0, err_orphan=0.
  - Tag FIFO is emptied; the round-robin pointer is set so requester 0 has top priority.
- Credit:
  - issue_ok = (inflight < MAX_INFLIGHT) OR tree_dout_tvalid in the same cycle (a pop frees a slot the same cycle).
- Arbitration:
  - When issue_ok, req_ready is set for the first requester with req_valid=1, searching from (last_grant+1) mod REQ upward with wrap.
  - req_ready is 0 for all requesters when issue_ok=0 or no request is pending.
  - last_grant updates only on a completed handshake (req_valid & req_ready).
  - A requester holds req_valid and req_data stable until granted.
- Issue:
  - A handshake in cycle T loads tree_din with the granted slice and drives tree_din_tvalid=all-ones in cycle T+1; otherwise tree_din_tvalid=0 and tree_din holds its value.
  - The granted id is pushed to the tag FIFO at the T edge.
  - Back-to-back issues are allowed every cycle.
- Return:
  - When tree_dout_tvalid is high with the FIFO non-empty, the head id is popped. In the next cycle res_valid[id]=1 (one-hot, single cycle), res_data=tree_dout, res_id=id.
  - res_data and res_id hold between results.
  - Results are strictly in issue order; the tree preserves order.
  - End-to-end latency is handshake cycle T to res_valid at T+2+L, where L is the tree latency.
- Counter:
  - Push only: inflight+1. Pop only: inflight−1. Both or neither: unchanged.
  - The FIFO never overflows, by construction of issue_ok.
- Orphan:
  - tree_dout_tvalid with the FIFO empty: no pop, no res_valid, inflight unchanged, err_orphan set to 1.
  - err_orphan is cleared only by rst.
- Reset mid-operation:
  - Outstanding tags are discarded. Because the tree is not reset, its stale results then appear as orphans.
  - Integrators hold rst for at least L cycles, or tolerate err_orphan after reset.
- Wrap-around:
  - FIFO pointers wrap modulo MAX_INFLIGHT.
  - The round-robin search wraps from REQ−1 to 0.

Test Plan:
- Single request: after reset, req_valid=4'b0100 with slice 2=64'h0102030405060708 → req_ready=4'b0100 the same cycle; next cycle tree_din=64'h0102030405060708 and tree_din_tvalid=8'hFF; one cycle after the tree model returns 32'h1234_5678: res_valid=4'b0100, res_id=2, res_data=32'h1234_5678; inflight goes 0→1→0.
- Fairness: req_valid=4'b1111 held, tree model L=3, MAX_INFLIGHT=8 → grants in order 0,1,2,3,0,1,… one per cycle; results return to ids in the same order; inflight saturates at 4.
- Credit limit: tree model L=20, all requesting → exactly 8 consecutive issues, then req_ready=0 with inflight=8; issues resume in the same cycle as the first tree_dout_tvalid.
- Simultaneous pop and push at inflight=8 → the issue is granted, inflight stays 8, the popped id receives res_valid, and the new tag sits at the FIFO tail.
- Orphan: a single tree_dout_tvalid pulse with the FIFO empty → res_valid stays 0, err_orphan=1 and remains 1 through subsequent normal traffic until rst.
- Reset mid-run: assert rst with inflight=5 → all outputs 0 immediately (async); after release, req_valid=4'b1010 → requester 1 is granted first.

Source files
------------

// File: rtl/mult_tree_arbiter.sv
// Round-robin front end that shares one pipelined product tree among REQ requesters.
// Each issued requester id is queued in an in-order tag FIFO so tree results route back to their owner.
module mult_tree_arbiter #(
    parameter  int NUM          = 8,
    parameter  int DATA_WIDTH   = 8,
    parameter  int REQ          = 4,
    parameter  int MAX_INFLIGHT = 8,
    localparam int ID_W         = $clog2(REQ),
    localparam int CNT_W        = $clog2(MAX_INFLIGHT) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [REQ-1:0]                 req_valid,
    input  logic [REQ*NUM*DATA_WIDTH-1:0]  req_data,
    output logic [REQ-1:0]                 req_ready,
    output logic [NUM*DATA_WIDTH-1:0]      tree_din,
    output logic [NUM-1:0]                 tree_din_tvalid,
    input  logic [31:0]                    tree_dout,
    input  logic                           tree_dout_tvalid,
    output logic [REQ-1:0]                 res_valid,
    output logic [31:0]                    res_data,
    output logic [ID_W-1:0]                res_id,
    output logic [CNT_W-1:0]               inflight,
    output logic                           busy,
    output logic                           err_orphan
);

    localparam int OP_W  = NUM * DATA_WIDTH;
    localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

    logic [OP_W-1:0]  tree_din_q, tree_din_d;
    logic             din_valid_q, din_valid_d;
    logic [REQ-1:0]   res_valid_q, res_valid_d;
    logic [31:0]      res_data_q, res_data_d;
    logic [ID_W-1:0]  res_id_q, res_id_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic             err_orphan_q, err_orphan_d;
    logic [ID_W-1:0]  last_grant_q, last_grant_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ID_W-1:0]  tag_mem_q [MAX_INFLIGHT];

    logic            issue_ok;
    logic            push;
    logic            pop;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] head_id;

    // A result leaving the tree frees its slot in the same cycle, so a full pipe can still issue.
    assign issue_ok = (inflight_q < CNT_W'(MAX_INFLIGHT)) || tree_dout_tvalid;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        req_ready = '0;
        grant_id  = '0;
        cand      = '0;
        if (issue_ok) begin
            // Scan from lowest to highest priority; the last hit wins, i.e. the one nearest last_grant+1.
            for (int i = REQ; i >= 1; i--) begin
                cand = ID_W'((int'(last_grant_q) + i) % REQ);
                if (req_valid[cand]) begin
                    req_ready       = '0;
                    req_ready[cand] = 1'b1;
                    grant_id        = cand;
                end
            end
        end
    end

    assign push    = |(req_valid & req_ready);
    assign head_id = tag_mem_q[rd_ptr_q];
    assign pop     = tree_dout_tvalid && (inflight_q != '0);

    always_comb begin
        tree_din_d   = tree_din_q;
        din_valid_d  = push;
        res_valid_d  = '0;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        err_orphan_d = err_orphan_q | (tree_dout_tvalid & ~pop);
        last_grant_d = last_grant_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        inflight_d   = inflight_q;
        if (push) begin
            tree_din_d   = req_data[grant_id*OP_W +: OP_W];
            last_grant_d = grant_id;
            wr_ptr_d     = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            res_valid_d[head_id] = 1'b1;
            res_data_d           = tree_dout;
            res_id_d             = head_id;
            rd_ptr_d             = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tree_din_q   <= '0;
            din_valid_q  <= 1'b0;
            res_valid_q  <= '0;
            res_data_q   <= '0;
            res_id_q     <= '0;
            inflight_q   <= '0;
            err_orphan_q <= 1'b0;
            last_grant_q <= ID_W'(REQ - 1);
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            tree_din_q   <= tree_din_d;
            din_valid_q  <= din_valid_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
            inflight_q   <= inflight_d;
            err_orphan_q <= err_orphan_d;
            last_grant_q <= last_grant_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // NOTE: tag storage has no reset; an entry is only read after the counter marks it valid.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= grant_id;
        end
    end

    assign tree_din        = tree_din_q;
    assign tree_din_tvalid = {NUM{din_valid_q}};
    assign res_valid       = res_valid_q;
    assign res_data        = res_data_q;
    assign res_id          = res_id_q;
    assign inflight        = inflight_q;
    assign busy            = (inflight_q != '0);
    assign err_orphan      = err_orphan_q;

endmodule
